// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, default widths and helpers for the programmable clock divider
package clk_div_pkg;

    localparam int CNT_WIDTH_DEFAULT   = 12;
    localparam int STEP_WIDTH_DEFAULT  = 8;
    localparam int HALF_PERIOD_DEFAULT = 1302;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STEP     = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

    // A half-period of zero cannot be counted, so it is promoted to one cycle.
    function automatic logic [31:0] sat_div(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// rtl/clk_div_counter.sv - loadable down-counter that stops at zero and flags it
module clk_div_counter #(
    parameter int CNT_WIDTH = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_load,
    input  logic                 i_enable,
    input  logic [CNT_WIDTH-1:0] i_load_value,
    output logic                 o_zero
);

    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_value;
        end else if (i_enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/clk_divider_prog.sv
// rtl/clk_divider_prog.sv - runtime-programmable clock divider with run, step burst, stop and abort
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int                   CNT_WIDTH         = CNT_WIDTH_DEFAULT,
    parameter logic [CNT_WIDTH-1:0] HALF_PERIOD_RESET = CNT_WIDTH'(HALF_PERIOD_DEFAULT),
    parameter int                   STEP_WIDTH        = STEP_WIDTH_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start_stb,
    input  logic                  i_step_stb,
    input  logic [STEP_WIDTH-1:0] i_step_count,
    input  logic                  i_stop_stb,
    input  logic                  i_abort_stb,
    input  logic                  i_div_load_stb,
    input  logic [CNT_WIDTH-1:0]  i_div_value,
    output logic                  o_div_clk,
    output logic                  o_rise_stb,
    output logic                  o_fall_stb,
    output logic                  o_busy
);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  div_q;
    logic [CNT_WIDTH-1:0]  div_new;
    logic [CNT_WIDTH-1:0]  reload_val;
    logic [STEP_WIDTH-1:0] rem_q, rem_d;
    logic                  div_clk_q, div_clk_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  busy_q;
    logic                  cnt_load, cnt_en, cnt_zero;
    logic [CNT_WIDTH-1:0]  cnt_load_val;
    logic                  stop_req;

    // A divisor written in the same cycle as a reload is used by that reload.
    assign div_new    = CNT_WIDTH'(sat_div(32'(i_div_value)));
    assign reload_val = (i_div_load_stb ? div_new : div_q) - CNT_WIDTH'(1);
    assign stop_req   = i_stop_stb && ((state_q == ST_RUN) || (state_q == ST_STEP));

    clk_div_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_load       (cnt_load),
        .i_enable     (cnt_en),
        .i_load_value (cnt_load_val),
        .o_zero       (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        div_clk_d    = div_clk_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = reload_val;

        if (i_abort_stb) begin
            state_d      = ST_IDLE;
            div_clk_d    = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start_stb) begin
                        state_d  = ST_RUN;
                        cnt_load = 1'b1;
                    end else if (i_step_stb && (i_step_count != '0)) begin
                        state_d  = ST_STEP;
                        rem_d    = i_step_count;
                        cnt_load = 1'b1;
                    end
                end
                default: begin
                    if (stop_req && div_clk_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_en = 1'b1;
                        if (cnt_zero) begin
                            cnt_load  = 1'b1;
                            div_clk_d = ~div_clk_q;
                            rise_d    = ~div_clk_q;
                            fall_d    = div_clk_q;
                            // Every way of leaving an active state on its own ends on a rise.
                            if (!div_clk_q) begin
                                if ((state_q == ST_STOPPING) || stop_req ||
                                    ((state_q == ST_STEP) && (rem_q == STEP_WIDTH'(1)))) begin
                                    state_d = ST_IDLE;
                                end else if (state_q == ST_STEP) begin
                                    rem_d = rem_q - STEP_WIDTH'(1);
                                end
                            end
                        end else if (stop_req) begin
                            state_d = ST_STOPPING;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            div_q     <= HALF_PERIOD_RESET;
            rem_q     <= '0;
            div_clk_q <= 1'b1;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            div_clk_q <= div_clk_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            busy_q    <= (state_d != ST_IDLE);
            if (i_div_load_stb) begin
                div_q <= div_new;
            end
        end
    end

    assign o_div_clk  = div_clk_q;
    assign o_rise_stb = rise_q;
    assign o_fall_stb = fall_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// tb/tb_clk_divider_prog.sv - directed and randomized checks of clk_divider_prog against an edge-time model
module tb_clk_divider_prog;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_STOP = 3;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_start_stb;
    logic        i_step_stb;
    logic [7:0]  i_step_count;
    logic        i_stop_stb;
    logic        i_abort_stb;
    logic        i_div_load_stb;
    logic [11:0] i_div_value;
    logic        o_div_clk;
    logic        o_rise_stb;
    logic        o_fall_stb;
    logic        o_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0;
    int drop;
    int rise_q[$];
    int fall_q[$];

    int   m_mode;
    int   m_h;
    int   m_next;
    int   m_left;
    logic m_level;
    logic m_rise;
    logic m_fall;

    clk_divider_prog dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_start_stb    (i_start_stb),
        .i_step_stb     (i_step_stb),
        .i_step_count   (i_step_count),
        .i_stop_stb     (i_stop_stb),
        .i_abort_stb    (i_abort_stb),
        .i_div_load_stb (i_div_load_stb),
        .i_div_value    (i_div_value),
        .o_div_clk      (o_div_clk),
        .o_rise_stb     (o_rise_stb),
        .o_fall_stb     (o_fall_stb),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Reference: each phase is scheduled as an absolute edge number h cycles after its start.
    task automatic model_edge();
        int h_eff;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!i_reset_n) begin
            m_mode  = M_IDLE;
            m_h     = 1302;
            m_level = 1'b1;
            return;
        end
        h_eff = i_div_load_stb ? ((i_div_value == 0) ? 1 : int'(i_div_value)) : m_h;
        m_h   = h_eff;
        if (i_abort_stb) begin
            m_mode  = M_IDLE;
            m_level = 1'b1;
        end else if (m_mode == M_IDLE) begin
            if (i_start_stb) begin
                m_mode = M_RUN;
                m_next = cyc + h_eff;
            end else if (i_step_stb && i_step_count != 0) begin
                m_mode = M_STEP;
                m_left = int'(i_step_count);
                m_next = cyc + h_eff;
            end
        end else if (i_stop_stb && m_mode != M_STOP && m_level) begin
            m_mode = M_IDLE;
        end else if (cyc == m_next) begin
            m_level = !m_level;
            m_next  = cyc + h_eff;
            if (m_level) begin
                m_rise = 1'b1;
                if (m_mode == M_STOP || i_stop_stb || (m_mode == M_STEP && m_left == 1))
                    m_mode = M_IDLE;
                else if (m_mode == M_STEP)
                    m_left--;
            end else begin
                m_fall = 1'b1;
            end
        end else if (i_stop_stb && m_mode != M_STOP && !m_level) begin
            m_mode = M_STOP;
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        cyc++;
        model_edge();
        #2;
        chk("div_clk", 32'(o_div_clk), 32'(m_level));
        chk("rise_stb", 32'(o_rise_stb), 32'(m_rise));
        chk("fall_stb", 32'(o_fall_stb), 32'(m_fall));
        chk("busy", 32'(o_busy), 32'(m_mode != M_IDLE));
        if (o_rise_stb === 1'b1) rise_q.push_back(cyc);
        if (o_fall_stb === 1'b1) fall_q.push_back(cyc);
        i_start_stb    = 1'b0;
        i_step_stb     = 1'b0;
        i_stop_stb     = 1'b0;
        i_abort_stb    = 1'b0;
        i_div_load_stb = 1'b0;
    endtask

    task automatic load_div(input int v);
        i_div_load_stb = 1'b1;
        i_div_value    = 12'(v);
        tick();
    endtask

    task automatic clear_q();
        rise_q.delete();
        fall_q.delete();
    endtask

    initial begin
        i_reset_n      = 1'b0;
        i_start_stb    = 1'b0;
        i_step_stb     = 1'b0;
        i_step_count   = 8'd0;
        i_stop_stb     = 1'b0;
        i_abort_stb    = 1'b0;
        i_div_load_stb = 1'b0;
        i_div_value    = 12'd0;
        m_mode = M_IDLE; m_h = 1302; m_level = 1'b1; m_next = 0; m_left = 0;

        repeat (2) tick();
        chk("rst_div_clk", 32'(o_div_clk), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        i_reset_n = 1'b1;
        tick();

        // default half-period after reset
        clear_q();
        i_start_stb = 1'b1; t0 = cyc + 1; tick();
        chk("dflt_busy", 32'(o_busy), 32'd1);
        repeat (1302 + 2604) tick();
        chk("dflt_fall0", qget(fall_q, 0), t0 + 1302);
        chk("dflt_period", qget(fall_q, 1) - qget(fall_q, 0), 2604);
        i_abort_stb = 1'b1; tick();

        // free-run at h=3
        load_div(3); clear_q();
        i_start_stb = 1'b1; t0 = cyc + 1; tick();
        repeat (12) tick();
        chk("fr_fall0", qget(fall_q, 0), t0 + 3);
        chk("fr_rise0", qget(rise_q, 0), t0 + 6);
        chk("fr_fall1", qget(fall_q, 1), t0 + 9);
        chk("fr_rise1", qget(rise_q, 1), t0 + 12);
        i_abort_stb = 1'b1; tick();

        // step burst h=2 N=3 with an ignored start in the middle
        load_div(2); clear_q(); drop = -1;
        i_step_stb = 1'b1; i_step_count = 8'd3; t0 = cyc + 1; tick();
        repeat (4) tick();
        i_start_stb = 1'b1; tick();
        repeat (15) begin
            tick();
            if (o_busy === 1'b0 && drop < 0) drop = cyc;
        end
        chk("step_rises", rise_q.size(), 3);
        chk("step_last", qget(rise_q, 2), t0 + 12);
        chk("step_drop", drop, t0 + 12);

        // graceful stop while low, then stop while high
        load_div(4); clear_q();
        i_start_stb = 1'b1; t0 = cyc + 1; tick();
        repeat (4) tick();
        i_stop_stb = 1'b1; tick();
        repeat (8) tick();
        chk("gs_rises", rise_q.size(), 1);
        chk("gs_rise_at", qget(rise_q, 0), t0 + 8);
        chk("gs_falls", fall_q.size(), 1);
        clear_q();
        i_start_stb = 1'b1; tick();
        tick();
        i_stop_stb = 1'b1; tick();
        chk("sh_busy", 32'(o_busy), 32'd0);
        repeat (8) tick();
        chk("sh_falls", fall_q.size(), 0);

        // divisor change mid-phase, then zero load
        load_div(3); clear_q();
        i_start_stb = 1'b1; t0 = cyc + 1; tick();
        repeat (4) tick();
        load_div(5);
        repeat (11) tick();
        chk("dv_rise0", qget(rise_q, 0), t0 + 6);
        chk("dv_fall1", qget(fall_q, 1), t0 + 11);
        chk("dv_rise1", qget(rise_q, 1), t0 + 16);
        load_div(0);
        repeat (7) tick();
        chk("dv_fall2", qget(fall_q, 2), t0 + 21);
        chk("dv_rise2", qget(rise_q, 2), t0 + 22);
        chk("dv_fall3", qget(fall_q, 3), t0 + 23);
        i_abort_stb = 1'b1; tick();

        // abort while low; abort together with start in idle
        load_div(4);
        i_start_stb = 1'b1; tick();
        repeat (5) tick();
        i_abort_stb = 1'b1; tick();
        chk("ab_div_clk", 32'(o_div_clk), 32'd1);
        chk("ab_rise", 32'(o_rise_stb), 32'd0);
        chk("ab_busy", 32'(o_busy), 32'd0);
        clear_q();
        i_abort_stb = 1'b1; i_start_stb = 1'b1; tick();
        chk("abst_busy", 32'(o_busy), 32'd0);
        repeat (8) tick();
        chk("abst_falls", fall_q.size(), 0);

        // reset during a step burst restores the default divisor
        load_div(7);
        i_step_stb = 1'b1; i_step_count = 8'd5; tick();
        repeat (20) tick();
        i_reset_n = 1'b0; tick();
        chk("rs_div_clk", 32'(o_div_clk), 32'd1);
        chk("rs_busy", 32'(o_busy), 32'd0);
        chk("rs_strobes", 32'({o_rise_stb, o_fall_stb}), 32'd0);
        i_reset_n = 1'b1; tick(); clear_q();
        i_start_stb = 1'b1; t0 = cyc + 1; tick();
        repeat (1302) tick();
        chk("rs_fall0", qget(fall_q, 0), t0 + 1302);
        i_abort_stb = 1'b1; tick();

        // randomized control traffic against the model
        repeat (600) begin
            i_start_stb    = ($urandom_range(0, 15) == 0);
            i_step_stb     = ($urandom_range(0, 15) == 0);
            i_step_count   = 8'($urandom_range(0, 4));
            i_stop_stb     = ($urandom_range(0, 31) == 0);
            i_abort_stb    = ($urandom_range(0, 63) == 0);
            i_div_load_stb = ($urandom_range(0, 15) == 0);
            i_div_value    = 12'($urandom_range(0, 6));
            i_reset_n      = ($urandom_range(0, 299) != 0);
            tick();
        end
        i_reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_divider_prog.md
# clk_divider_prog

Runtime-programmable successor to the fixed-rate clock divider. It generates a divided clock (Z80 CPU clock, UART baud tick) from `i_clk`. The half-period is loaded at runtime. It supports free-run, N-cycle single-step bursts, graceful stop and immediate abort, and emits one-cycle edge strobes for logic clocked by `i_clk`. It sits between the control/debug FSM and the clocked peripherals.

## Interface
- `CNT_WIDTH`, 12: width of the half-period counter and divisor.
- `HALF_PERIOD_RESET`, 12'd1302: divisor value after reset.
- `STEP_WIDTH`, 8: width of the step-count input.
- `i_clk` in 1: system clock. One clock domain only.
- `i_reset_n` in 1: reset. Synchronous, active-low.
- `i_start_stb` in 1: begin free-run from IDLE.
- `i_step_stb` in 1: begin an N-cycle burst from IDLE.
- `i_step_count` in STEP_WIDTH: N, sampled with `i_step_stb`.
- `i_stop_stb` in 1: graceful stop at the end of the current cycle.
- `i_abort_stb` in 1: immediate stop and counter reset.
- `i_div_load_stb` in 1: load a new half-period.
- `i_div_value` in CNT_WIDTH: new half-period h, in `i_clk` cycles.
- `o_div_clk` out 1: divided clock. Idle level is 1.
- `o_rise_stb` out 1: high in the cycle `o_div_clk` becomes 1.
- `o_fall_stb` out 1: high in the cycle `o_div_clk` becomes 0.
- `o_busy` out 1: state != IDLE.

## Operation
- States:
  - IDLE: output 1, counter held.
  - RUN: free-running.
  - STEP: burst of N cycles.
  - STOPPING: finish the low phase, then go idle.
- Divisor register `div_q`:
  - Reset value is HALF_PERIOD_RESET.
  - `i_div_load_stb` writes `div_q`. A value of 0 is stored as 1.
  - A load takes effect at the next counter reload. Reloads happen at start, step and every toggle.
  - A load in the same cycle as a reload uses the new value.
- Counter reload value is h-1, where h = `div_q`. In any active state, each cycle:
  - If the counter is 0: toggle `o_div_clk`, reload h-1, assert the matching edge strobe.
  - Otherwise: decrement the counter.
- IDLE transitions:
  - `i_start_stb` → RUN.
  - `i_step_stb` with N≠0 → STEP; remaining = N.
  - `i_step_stb` with N=0 is ignored.
  - `i_start_stb` and `i_step_stb` together: start wins.
- Start/step strobes in any non-IDLE state are ignored.
- STEP:
  - Each rising toggle decrements the remaining count.
  - The rising toggle with remaining == 1 → IDLE.
- `i_stop_stb` in RUN or STEP:
  - If `o_div_clk` = 1 → IDLE next cycle. No further edges.
  - If `o_div_clk` = 0 → STOPPING. The next scheduled rise → IDLE.
- `i_abort_stb` in any state:
  - Next cycle: IDLE, `o_div_clk` = 1, counter = 0, strobes = 0.
  - No rise strobe is emitted for a forced high.
- Priority: reset > abort > stop > start/step > counting.
- `o_div_clk` never glitches. Every phase has length exactly h cycles, except when cut short by abort.

## Timing
- All outputs are registered.
- Reset values: `o_div_clk` = 1, `o_rise_stb` = 0, `o_fall_stb` = 0, `o_busy` = 0, state IDLE, `div_q` = HALF_PERIOD_RESET.
- Start sampled at edge T:
  - `o_busy` = 1 from T+1.
  - First fall at edge T+h, first rise at T+2h.
  - Period is 2h; duty is 50%.
- Step with N: last rise at T+2hN; `o_busy` = 0 from edge T+2hN.
- Edge strobes are coincident with the `o_div_clk` transition and last exactly one cycle.
- Stop latency:
  - Output high: 1 cycle.
  - Output low: at most h cycles, ending on a normal rise with `o_rise_stb` asserted.
- Abort latency is 1 cycle.
- Reset asserted mid-operation: all reset values apply at the next edge, including `div_q`.

## Structure
- Package `clk_div_pkg` holds:
  - State enum encoding (IDLE, RUN, STEP, STOPPING).
  - Default width constants.
  - Function `sat_div(value)` mapping 0 → 1.
- Sub-module `clk_div_counter`: loadable down-counter with a `load`/`enable` interface, a CNT_WIDTH parameter and an `o_zero` flag.
- The top level holds the FSM, `div_q`, the step counter and the output registers.

## Test plan
- **Reset defaults:** reset, then start with default h=1302 → first fall 1302 cycles after start, period 2604, `o_busy` = 1.
- **Free-run:** load h=3, start at T → falls at T+3 and T+9, rises at T+6 and T+12; `o_fall_stb`/`o_rise_stb` are single-cycle and aligned with the output.
- **Step burst:** h=2, step N=3 at T → exactly 3 rises, the last at T+12; `o_busy` drops at T+12; a second start during the burst is ignored.
- **Graceful stop:** h=4, stop issued 1 cycle after a fall → the low phase completes (full 4 cycles), one rise strobe, then IDLE. Stop while high → IDLE next cycle with no fall strobe.
- **Divisor change and zero load:** running at h=3, load 5 mid-phase → the current phase stays 3 cycles and subsequent phases are 5. Load 0 → phases of 1 cycle, so the output toggles every cycle.
- **Abort and priority:** abort while low → next cycle `o_div_clk` = 1, no rise strobe, `o_busy` = 0. Abort+start together in IDLE → stays IDLE. Reset during STEP → all outputs at reset values and h restored to 1302.
